// File: rtl/mips_pipeline_pkg.sv
// Shared MIPS pipeline definitions: control-word layout, ALUOp encodings and
// the all-zero bubble control word.
package mips_pipeline_pkg;

    // ctrl = {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[2:0]}
    localparam int CTRL_WIDTH     = 10;
    localparam int CTRL_REGDST    = 9;
    localparam int CTRL_ALUSRC    = 8;
    localparam int CTRL_MEMTOREG  = 7;
    localparam int CTRL_REGWRITE  = 6;
    localparam int CTRL_MEMREAD   = 5;
    localparam int CTRL_MEMWRITE  = 4;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_ALUOP_MSB = 2;
    localparam int CTRL_ALUOP_LSB = 0;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_RTYPE = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4,
        ALUOP_SLT   = 3'd5
    } aluop_e;

    localparam logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0;

    function automatic logic ctrl_mem_read(input logic [CTRL_WIDTH-1:0] c);
        return c[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/id_ex_stage_register_hazard.sv
// Combinational load-use hazard detector: a load sitting in EX whose target
// is read by the instruction in ID forces one bubble. Register 0 is exempt.
module load_use_hazard_detector #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit ENABLE         = 1'b1
) (
    input  logic                      ex_valid_i,
    input  logic                      ex_mem_read_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt_i,
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
    output logic                      stall_o
);

    assign stall_o = ENABLE & ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) & id_valid_i
                   & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with valid bit, cache-miss freeze, branch flush,
// load-use bubble insertion and a saturating bubble counter.
module id_ex_stage_register
    import mips_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FUNCT_WIDTH    = 6,
    parameter int ENABLE_HAZARD  = 1,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      hit,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     read_data_1,
    input  logic [DATA_WIDTH-1:0]     read_data_2,
    input  logic [DATA_WIDTH-1:0]     sign_extended_immediate,
    input  logic [CTRL_WIDTH-1:0]     ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [REG_ADDR_WIDTH-1:0] rt,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic [FUNCT_WIDTH-1:0]    funct,
    input  logic [PC_WIDTH-1:0]       next_PC,
    output logic                      load_use_stall,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     read_data_1_output,
    output logic [DATA_WIDTH-1:0]     read_data_2_output,
    output logic [DATA_WIDTH-1:0]     sign_extended_immediate_output,
    output logic [CTRL_WIDTH-1:0]     ctrl_output,
    output logic [REG_ADDR_WIDTH-1:0] rt_output,
    output logic [REG_ADDR_WIDTH-1:0] rd_output,
    output logic [FUNCT_WIDTH-1:0]    funct_output,
    output logic [PC_WIDTH-1:0]       next_PC_output,
    output logic [COUNT_WIDTH-1:0]    bubble_count
);

    logic                      valid_q, valid_d;
    logic [CTRL_WIDTH-1:0]     ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]     rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [FUNCT_WIDTH-1:0]    funct_q, funct_d;
    logic [PC_WIDTH-1:0]       pc_q, pc_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;

    // Hazard is evaluated against the registered EX-side fields, so it stays
    // meaningful during a freeze.
    load_use_hazard_detector #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .ENABLE         (ENABLE_HAZARD != 0)
    ) u_hazard (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_mem_read(ctrl_q)),
        .ex_rt_i       (rt_q),
        .id_valid_i    (in_valid),
        .id_rs_i       (rs),
        .id_rt_i       (rt),
        .stall_o       (load_use_stall)
    );

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        funct_d = funct_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (hit) begin
            if (flush || load_use_stall) begin
                valid_d = 1'b0;
                ctrl_d  = BUBBLE_CTRL;
                rd1_d   = '0;
                rd2_d   = '0;
                imm_d   = '0;
                rt_d    = '0;
                rd_d    = '0;
                funct_d = '0;
                pc_d    = '0;
                // Only hazard bubbles are counted; flush bubbles are not.
                if (!flush && count_q != {COUNT_WIDTH{1'b1}})
                    count_d = count_q + 1'b1;
            end else begin
                valid_d = in_valid;
                ctrl_d  = in_valid ? ctrl : BUBBLE_CTRL;
                rd1_d   = read_data_1;
                rd2_d   = read_data_2;
                imm_d   = sign_extended_immediate;
                rt_d    = rt;
                rd_d    = rd;
                funct_d = funct;
                pc_d    = next_PC;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_CTRL;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign out_valid                      = valid_q;
    assign ctrl_output                    = ctrl_q;
    assign read_data_1_output             = rd1_q;
    assign read_data_2_output             = rd2_q;
    assign sign_extended_immediate_output = imm_q;
    assign rt_output                      = rt_q;
    assign rd_output                      = rd_q;
    assign funct_output                   = funct_q;
    assign next_PC_output                 = pc_q;
    assign bubble_count                   = count_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for id_ex_stage_register: three builds (default, hazard disabled,
// 2-bit counter) share one stimulus stream and a behavioural model.
module tb_id_ex_stage_register;

    localparam int NI = 3;
    localparam int MEMREAD_BIT = 5;
    localparam logic [9:0] C_RTYPE = 10'h242;  // RegDst, RegWrite, ALUOp=RTYPE
    localparam logic [9:0] C_LW    = 10'h1E0;  // ALUSrc, MemtoReg, RegWrite, MemRead

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, hit, flush, in_valid;
    logic [31:0] read_data_1, read_data_2, sign_extended_immediate, next_PC;
    logic [9:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;

    logic [NI-1:0]        o_stall, o_valid;
    logic [NI-1:0][9:0]   o_ctrl;
    logic [NI-1:0][31:0]  o_d1, o_d2, o_imm, o_pc;
    logic [NI-1:0][4:0]   o_rt, o_rd;
    logic [NI-1:0][5:0]   o_f;
    logic [NI-1:0][15:0]  o_cnt;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CWG = (g == 2) ? 2 : 16;
        localparam int ENG = (g == 1) ? 0 : 1;
        logic [CWG-1:0] cnt_w;
        id_ex_stage_register #(
            .DATA_WIDTH(32), .PC_WIDTH(32), .REG_ADDR_WIDTH(5), .FUNCT_WIDTH(6),
            .ENABLE_HAZARD(ENG), .COUNT_WIDTH(CWG)
        ) dut (
            .clock(clock), .reset_n(reset_n), .hit(hit), .flush(flush), .in_valid(in_valid),
            .read_data_1(read_data_1), .read_data_2(read_data_2),
            .sign_extended_immediate(sign_extended_immediate), .ctrl(ctrl),
            .rs(rs), .rt(rt), .rd(rd), .funct(funct), .next_PC(next_PC),
            .load_use_stall(o_stall[g]), .out_valid(o_valid[g]),
            .read_data_1_output(o_d1[g]), .read_data_2_output(o_d2[g]),
            .sign_extended_immediate_output(o_imm[g]), .ctrl_output(o_ctrl[g]),
            .rt_output(o_rt[g]), .rd_output(o_rd[g]), .funct_output(o_f[g]),
            .next_PC_output(o_pc[g]), .bubble_count(cnt_w)
        );
        assign o_cnt[g] = 16'(cnt_w);
    end

    // Behavioural model: one record per build describing what EX holds.
    typedef struct {
        bit         v;
        logic [9:0] ctrl;
        logic [31:0] d1, d2, imm, pc;
        logic [4:0] rt, rd;
        logic [5:0] f;
        int         cnt;
    } st_t;

    st_t m [NI];

    function automatic bit en_of(int g);   return g != 1; endfunction
    function automatic int max_of(int g);  return (g == 2) ? 3 : 65535; endfunction

    function automatic bit model_stall(int g);
        return en_of(g) && m[g].v && m[g].ctrl[MEMREAD_BIT] && m[g].rt != 0 && in_valid
               && (m[g].rt == rs || m[g].rt == rt);
    endfunction

    initial for (int g = 0; g < NI; g++) m[g] = '{default: 0};

    always @(posedge clock) begin
        for (int g = 0; g < NI; g++) begin
            automatic bit st = model_stall(g);
            automatic int c  = m[g].cnt;
            if (!reset_n) m[g] = '{default: 0};
            else if (hit) begin
                if (flush || st) begin
                    m[g] = '{default: 0};
                    m[g].cnt = flush ? c : ((c + 1 > max_of(g)) ? max_of(g) : c + 1);
                end else begin
                    m[g].v    = in_valid;
                    m[g].ctrl = in_valid ? ctrl : 10'd0;
                    m[g].d1   = read_data_1;
                    m[g].d2   = read_data_2;
                    m[g].imm  = sign_extended_immediate;
                    m[g].rt   = rt;
                    m[g].rd   = rd;
                    m[g].f    = funct;
                    m[g].pc   = next_PC;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [9:0] c, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        in_valid = 1'b1; ctrl = c; rs = s; rt = t; rd = d;
        read_data_1 = $urandom; read_data_2 = $urandom;
        sign_extended_immediate = $urandom; next_PC = $urandom; funct = 6'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hit = 1'b1; flush = 1'b0;
        present(C_LW, 5'd1, 5'd2, 5'd3);
        tick(); tick();
        for (int g = 0; g < NI; g += 2) begin
            total++; if (o_valid[g] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d] got=%0b want=0", g, o_valid[g]); end
            total++; if (o_ctrl[g] !== 10'd0) begin bad++; $display("FAIL reset_ctrl[%0d] got=%h want=0", g, o_ctrl[g]); end
            total++; if (o_d1[g] !== 32'd0 || o_pc[g] !== 32'd0) begin bad++; $display("FAIL reset_data[%0d] got=%0d/%0d want=0/0", g, o_d1[g], o_pc[g]); end
            total++; if (o_cnt[g] !== 16'd0) begin bad++; $display("FAIL reset_count[%0d] got=%0d want=0", g, o_cnt[g]); end
        end
    endtask

    task automatic test_load();
        reset_n = 1'b1; hit = 1'b1; flush = 1'b0; in_valid = 1'b1; ctrl = C_RTYPE;
        read_data_1 = 111; read_data_2 = 222; sign_extended_immediate = 333;
        rs = 5'd1; rt = 5'd4; rd = 5'd5; funct = 6'd6; next_PC = 777;
        tick();
        total++;
        if ({o_d1[0], o_d2[0], o_imm[0], o_pc[0]} !== {32'd111, 32'd222, 32'd333, 32'd777}) begin
            bad++; $display("FAIL load_data got=%0d/%0d/%0d/%0d want=111/222/333/777", o_d1[0], o_d2[0], o_imm[0], o_pc[0]);
        end
        total++;
        if ({o_rt[0], o_rd[0], o_f[0]} !== {5'd4, 5'd5, 6'd6}) begin
            bad++; $display("FAIL load_regs got=%0d/%0d/%0d want=4/5/6", o_rt[0], o_rd[0], o_f[0]);
        end
        total++;
        if (o_valid[0] !== 1'b1 || o_ctrl[0] !== C_RTYPE || o_cnt[0] !== 16'd0) begin
            bad++; $display("FAIL load_ctl got=%0b/%h/%0d want=1/242/0", o_valid[0], o_ctrl[0], o_cnt[0]);
        end
    endtask

    task automatic test_freeze();
        hit = 1'b0; read_data_1 = 999;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            tick();
            total++;
            if (o_d1[0] !== 32'd111 || o_valid[0] !== 1'b1) begin
                bad++; $display("FAIL freeze_hold%0d got=%0d/%0b want=111/1", i, o_d1[0], o_valid[0]);
            end
        end
        hit = 1'b1; flush = 1'b0;
        tick();
        total++;
        if (o_d1[0] !== 32'd999) begin bad++; $display("FAIL freeze_release got=%0d want=999", o_d1[0]); end
    endtask

    task automatic test_load_use();
        present(C_LW, 5'd2, 5'd8, 5'd0);
        tick();
        present(C_RTYPE, 5'd8, 5'd9, 5'd10);
        #1;
        total++;
        if (o_stall[0] !== 1'b1 || o_stall[1] !== 1'b0) begin
            bad++; $display("FAIL lu_stall got=%0b/%0b want=1/0", o_stall[0], o_stall[1]);
        end
        tick();
        total++;
        if (o_valid[0] !== 1'b0 || o_ctrl[0] !== 10'd0 || o_cnt[0] !== 16'd1 || o_d1[0] !== 32'd0) begin
            bad++; $display("FAIL lu_bubble got=%0b/%h/%0d/%0d want=0/0/1/0", o_valid[0], o_ctrl[0], o_cnt[0], o_d1[0]);
        end
        total++;
        if (o_valid[1] !== 1'b1 || o_rd[1] !== 5'd10 || o_cnt[1] !== 16'd0) begin
            bad++; $display("FAIL lu_nohazard got=%0b/%0d/%0d want=1/10/0", o_valid[1], o_rd[1], o_cnt[1]);
        end
        #1;
        total++;
        if (o_stall[0] !== 1'b0) begin bad++; $display("FAIL lu_selfclear got=%0b want=0", o_stall[0]); end
        tick();
        total++;
        if (o_valid[0] !== 1'b1 || o_rd[0] !== 5'd10 || o_cnt[0] !== 16'd1) begin
            bad++; $display("FAIL lu_capture got=%0b/%0d/%0d want=1/10/1", o_valid[0], o_rd[0], o_cnt[0]);
        end
    endtask

    task automatic test_zero_reg();
        present(C_LW, 5'd3, 5'd0, 5'd0);
        tick();
        present(C_RTYPE, 5'd0, 5'd0, 5'd7);
        #1;
        total++;
        if (o_stall[0] !== 1'b0) begin bad++; $display("FAIL zero_reg_stall got=%0b want=0", o_stall[0]); end
        tick();
        total++;
        if (o_valid[0] !== 1'b1 || o_cnt[0] !== 16'd1) begin
            bad++; $display("FAIL zero_reg_capture got=%0b/%0d want=1/1", o_valid[0], o_cnt[0]);
        end
    endtask

    task automatic test_flush_hazard();
        present(C_LW, 5'd2, 5'd8, 5'd0);
        tick();
        present(C_RTYPE, 5'd8, 5'd1, 5'd11);
        flush = 1'b1;
        #1;
        total++;
        if (o_stall[0] !== 1'b1) begin bad++; $display("FAIL flush_stall got=%0b want=1", o_stall[0]); end
        tick();
        flush = 1'b0;
        total++;
        if (o_valid[0] !== 1'b0 || o_ctrl[0] !== 10'd0 || o_cnt[0] !== 16'd1) begin
            bad++; $display("FAIL flush_bubble got=%0b/%h/%0d want=0/0/1", o_valid[0], o_ctrl[0], o_cnt[0]);
        end
    endtask

    task automatic test_reset_freeze();
        present(C_RTYPE, 5'd1, 5'd2, 5'd3);
        tick();
        hit = 1'b0; reset_n = 1'b0;
        tick();
        total++;
        if (o_valid[0] !== 1'b0 || o_d1[0] !== 32'd0 || o_ctrl[0] !== 10'd0 || o_cnt[0] !== 16'd0) begin
            bad++; $display("FAIL reset_in_freeze got=%0b/%0d/%h/%0d want=0/0/0/0", o_valid[0], o_d1[0], o_ctrl[0], o_cnt[0]);
        end
        hit = 1'b1; reset_n = 1'b1;
    endtask

    task automatic test_saturation();
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            present(C_LW, 5'd1, 5'd8, 5'd0);
            tick();
            present(C_RTYPE, 5'd8, 5'd2, 5'd4);
            tick();
            total++;
            if (o_cnt[2] !== 16'(sat_exp[i]) || o_cnt[0] !== 16'(i + 1)) begin
                bad++; $display("FAIL saturate%0d got=%0d/%0d want=%0d/%0d", i, o_cnt[2], o_cnt[0], sat_exp[i], i + 1);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset_n  = ($urandom_range(0, 99) >= 2);
            hit      = ($urandom_range(0, 99) < 85);
            flush    = ($urandom_range(0, 99) < 10);
            in_valid = ($urandom_range(0, 99) < 80);
            ctrl     = 10'($urandom);
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom);
            read_data_1 = $urandom; read_data_2 = $urandom;
            sign_extended_immediate = $urandom; next_PC = $urandom; funct = 6'($urandom);
            #1;
            for (int g = 0; g < NI; g++) begin
                total++;
                if (o_stall[g] !== model_stall(g)) begin
                    bad++; $display("FAIL rnd_stall[%0d] cyc=%0d got=%0b want=%0b", g, n, o_stall[g], model_stall(g));
                end
            end
            tick();
            for (int g = 0; g < NI; g++) begin
                total++;
                if (o_valid[g] !== m[g].v || o_ctrl[g] !== m[g].ctrl || o_cnt[g] !== 16'(m[g].cnt)) begin
                    bad++; $display("FAIL rnd_ctl[%0d] cyc=%0d got=%0b/%h/%0d want=%0b/%h/%0d", g, n,
                                    o_valid[g], o_ctrl[g], o_cnt[g], m[g].v, m[g].ctrl, m[g].cnt);
                end
                total++;
                if ({o_d1[g], o_d2[g], o_imm[g], o_pc[g], o_rt[g], o_rd[g], o_f[g]} !==
                    {m[g].d1, m[g].d2, m[g].imm, m[g].pc, m[g].rt, m[g].rd, m[g].f}) begin
                    bad++; $display("FAIL rnd_data[%0d] cyc=%0d got=%h/%h/%0d/%0d want=%h/%h/%0d/%0d", g, n,
                                    o_d1[g], o_pc[g], o_rt[g], o_rd[g], m[g].d1, m[g].pc, m[g].rt, m[g].rd);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; hit = 1'b1; flush = 1'b0; in_valid = 1'b0; ctrl = '0;
        read_data_1 = '0; read_data_2 = '0; sign_extended_immediate = '0; next_PC = '0;
        rs = '0; rt = '0; rd = '0; funct = '0;
        test_reset();
        test_load();
        test_freeze();
        test_load_use();
        test_zero_reg();
        test_flush_hazard();
        test_reset_freeze();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
